paddle_input_conditioner: RTL and testbench

Conditions the raw, asynchronous, active-low paddle push-buttons of one player into clean, debounced `move_up`/`move_down` levels for the paddle controller, plus one-cycle press-event pulses for the menu/serve logic. It sits directly upstream of the paddle controller, one instance per player. It synchronises each button, debounces it with a per-button state machine, and resolves simultaneous up/down presses.

---
 rtl/paddle_input_conditioner.sv | 211 +++++++++++++++++++++
 tb/tb_paddle_input_conditioner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/paddle_input_conditioner.sv
// Per-player paddle button conditioner: synchronise, debounce and arbitrate the up/down buttons.
// Optional feature macro: PADDLE_LAST_PRESS_WINS_EN (most recent press wins while both are held).

module paddle_debounce_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 251_750,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic db,
    output logic press
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A short release glitch falls back to PRESSED without a new press pulse.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign db    = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign press = press_q;

endmodule

module paddle_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 251_750,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic move_up,
    output logic move_down,
    output logic up_press,
    output logic down_press
);

    logic sync1_up_q, sync1_up_d, sync2_up_q, sync2_up_d;
    logic sync1_dn_q, sync1_dn_d, sync2_dn_q, sync2_dn_d;
    logic move_up_q, move_up_d, move_down_q, move_down_d;
    logic up_press_q, up_press_d, down_press_q, down_press_d;
    logic s_up, s_down, db_up, db_down, up_evt, down_evt;

    always_comb begin
        sync1_up_d   = btn_up_n;
        sync2_up_d   = sync1_up_q;
        sync1_dn_d   = btn_down_n;
        sync2_dn_d   = sync1_dn_q;
        up_press_d   = up_evt;
        down_press_d = down_evt;
    end

    // Synchronisers reset to the released level so a held button is re-debounced after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_up_q   <= 1'b1;
            sync2_up_q   <= 1'b1;
            sync1_dn_q   <= 1'b1;
            sync2_dn_q   <= 1'b1;
            move_up_q    <= 1'b0;
            move_down_q  <= 1'b0;
            up_press_q   <= 1'b0;
            down_press_q <= 1'b0;
        end else begin
            sync1_up_q   <= sync1_up_d;
            sync2_up_q   <= sync2_up_d;
            sync1_dn_q   <= sync1_dn_d;
            sync2_dn_q   <= sync2_dn_d;
            move_up_q    <= move_up_d;
            move_down_q  <= move_down_d;
            up_press_q   <= up_press_d;
            down_press_q <= down_press_d;
        end
    end

    assign s_up   = ~sync2_up_q;
    assign s_down = ~sync2_dn_q;

    paddle_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up_fsm (
        .clk  (clk),
        .rst  (rst),
        .s    (s_up),
        .db   (db_up),
        .press(up_evt)
    );

    paddle_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down_fsm (
        .clk  (clk),
        .rst  (rst),
        .s    (s_down),
        .db   (db_down),
        .press(down_evt)
    );

`ifdef PADDLE_LAST_PRESS_WINS_EN
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_UP   = 2'd1,
        PRIO_DOWN = 2'd2
    } prio_e;

    prio_e prio_q, prio_d;

    // Press pulses coincide with the first debounced cycle, so the updated priority is used at once.
    always_comb begin
        prio_d = prio_q;
        if (up_evt && down_evt) begin
            prio_d = PRIO_NONE;
        end else if (up_evt) begin
            prio_d = PRIO_UP;
        end else if (down_evt) begin
            prio_d = PRIO_DOWN;
        end
        move_up_d   = db_up;
        move_down_d = db_down;
        if (db_up && db_down) begin
            move_up_d   = (prio_d == PRIO_UP);
            move_down_d = (prio_d == PRIO_DOWN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= PRIO_NONE;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        move_up_d   = db_up;
        move_down_d = db_down;
    end
`endif

    assign move_up    = move_up_q;
    assign move_down  = move_down_q;
    assign up_press   = up_press_q;
    assign down_press = down_press_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for paddle_input_conditioner with DEBOUNCE_CYCLES=4 (7-edge press/release latency).
module tb_paddle_input_conditioner;

    localparam int unsigned DEB = 4;
`ifdef PADDLE_LAST_PRESS_WINS_EN
    localparam bit LPW = 1'b1;
`else
    localparam bit LPW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_up_n;
    logic btn_down_n;
    logic move_up;
    logic move_down;
    logic up_press;
    logic down_press;

    int n_checks = 0;
    int n_fail   = 0;

    paddle_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up_n  (btn_up_n),
        .btn_down_n(btn_down_n),
        .move_up   (move_up),
        .move_down (move_down),
        .up_press  (up_press),
        .down_press(down_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // {move_up, move_down, up_press, down_press}
    function automatic logic [7:0] outs();
        return {4'b0, move_up, move_down, up_press, down_press};
    endfunction

    initial begin
        int bad;
        logic [11:0] bounce_pat;

        rst        = 1'b0;
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        tick(3);
        check("reset_outs", outs(), 8'h0);
        rst = 1'b1;
        tick(3);
        check("idle_outs", outs(), 8'h0);

        // Up press: 7 edges from first low sample to move_up/up_press.
        btn_up_n = 1'b0;
        tick(7);
        check("up_early", outs(), 8'h0);
        tick(1);
        check("up_rise", outs(), 8'b1010);
        tick(1);
        check("up_pulse_once", outs(), 8'b1000);

        // Release glitch of 2 cycles while pressed.
        tick(3);
        btn_up_n = 1'b1;
        tick(2);
        btn_up_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (outs() != 8'b1000) bad++;
        end
        check("glitch_hold", 8'(bad), 8'd0);

        // Up release latency.
        btn_up_n = 1'b1;
        tick(7);
        check("up_rel_early", outs(), 8'b1000);
        tick(1);
        check("up_rel", outs(), 8'h0);
        tick(3);

        // Down bounce: low 3, high 1, low 3, then released; nothing may be accepted.
        bounce_pat = 12'b000100011111;
        bad = 0;
        for (int i = 11; i >= 0; i--) begin
            btn_down_n = bounce_pat[i];
            tick(1);
            if (outs() != 8'h0) bad++;
        end
        check("bounce_quiet", 8'(bad), 8'd0);

        // Then held low: normal latency.
        btn_down_n = 1'b0;
        tick(7);
        check("down_early", outs(), 8'h0);
        tick(1);
        check("down_rise", outs(), 8'b0101);
        tick(2);
        check("down_held", outs(), 8'b0100);

        // Async reset while held, then fresh debounce and pulse.
        #1 rst = 1'b0;
        #1 check("rst_async", outs(), 8'h0);
        tick(2);
        rst = 1'b1;
        tick(7);
        check("rst_early", outs(), 8'h0);
        tick(1);
        check("rst_repress", outs(), 8'b0101);
        btn_down_n = 1'b1;
        tick(10);
        check("down_idle", outs(), 8'h0);

        // Up held, down pressed 20 cycles later.
        btn_up_n = 1'b0;
        tick(20);
        btn_down_n = 1'b0;
        tick(7);
        check("lpw_before", outs(), 8'b1000);
        tick(1);
        check("lpw_after", outs(), LPW ? 8'b0101 : 8'b1101);
        tick(3);
        btn_down_n = 1'b1;
        tick(7);
        check("lpw_rel_early", outs(), LPW ? 8'b0100 : 8'b1100);
        tick(1);
        check("lpw_release", outs(), 8'b1000);
        btn_up_n = 1'b1;
        tick(10);
        check("lpw_idle", outs(), 8'h0);

        // Same-edge press of both buttons.
        btn_up_n   = 1'b0;
        btn_down_n = 1'b0;
        tick(8);
        check("both_rise", outs(), LPW ? 8'b0011 : 8'b1111);
        tick(4);
        check("both_hold", outs(), LPW ? 8'b0000 : 8'b1100);
        btn_up_n = 1'b1;
        tick(8);
        check("both_up_rel", outs(), 8'b0100);
        btn_down_n = 1'b1;
        tick(10);
        check("final_idle", outs(), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
